ham_secded_stream_decoder: RTL and testbench

HAM_SECDED_STREAM_DECODER -- requirements
Module: ham_secded_stream_decoder

---
 rtl/ham_pkg.sv | 35 +++
 rtl/ham_syndrome.sv | 28 ++
 rtl/ham_secded_stream_decoder.sv | 148 ++++++++++++++
 tb/tb_ham_secded_stream_decoder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ham_pkg.sv
// Shared Hamming SECDED geometry helpers: length derivation and data-to-position mapping.
package ham_pkg;

  function automatic int unsigned calc_n(input int unsigned m);
    return (32'd1 << m) - 32'd1;
  endfunction

  function automatic int unsigned calc_k(input int unsigned m);
    return calc_n(m) - m;
  endfunction

  function automatic int unsigned calc_cw(input int unsigned m);
    return calc_n(m) + 32'd1;
  endfunction

  function automatic logic is_pow2(input int unsigned p);
    return (p != 32'd0) && ((p & (p - 32'd1)) == 32'd0);
  endfunction

  // 1-based Hamming position of data bit j (j-th non-power-of-two position)
  function automatic int unsigned data_pos(input int unsigned j);
    int unsigned cnt;
    int unsigned pos;
    cnt = 32'd0;
    pos = 32'd0;
    for (int unsigned p = 1; p < 64; p++) begin
      if (!is_pow2(p) && (pos == 32'd0)) begin
        if (cnt == j) pos = p;
        cnt = cnt + 32'd1;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/ham_syndrome.sv
// Combinational Hamming syndrome and overall parity of a SECDED codeword.
module ham_syndrome
  import ham_pkg::*;
#(
  parameter int unsigned M = 4,
  localparam int unsigned N = calc_n(M),
  localparam int unsigned CW = calc_cw(M)
) (
  input  logic [CW-1:0] code_i,
  output logic [M-1:0]  s_o,
  output logic          p_o
);

  localparam int unsigned IW = $clog2(CW);
  localparam int unsigned SW = $clog2(M);

  always_comb begin
    s_o = '0;
    for (int unsigned p = 1; p <= N; p++) begin
      for (int unsigned b = 0; b < M; b++) begin
        if (((p >> b) & 32'd1) != 32'd0) s_o[SW'(b)] = s_o[SW'(b)] ^ code_i[IW'(p - 1)];
      end
    end
  end

  assign p_o = ^code_i;

endmodule

// File: rtl/ham_secded_stream_decoder.sv
// Two-stage valid/ready SECDED decoder: S1 holds code+syndrome, S2 holds corrected data and flags.
module ham_secded_stream_decoder
  import ham_pkg::*;
#(
  parameter int unsigned M = 4,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned N = calc_n(M),
  localparam int unsigned K = calc_k(M),
  localparam int unsigned CW = calc_cw(M)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [CW-1:0]    in_code,
  output logic             in_ready,
  output logic             out_valid,
  output logic [K-1:0]     out_data,
  output logic             out_sec,
  output logic             out_ded,
  input  logic             out_ready,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] sec_cnt,
  output logic [CNT_W-1:0] ded_cnt
);

  localparam int unsigned IW = $clog2(CW);
  localparam int unsigned KW = $clog2(K);

  logic             s1_valid_q, s1_valid_d;
  logic [CW-1:0]    s1_code_q, s1_code_d;
  logic [M-1:0]     s1_syn_q, s1_syn_d;
  logic             s1_par_q, s1_par_d;
  logic             out_valid_q, out_valid_d;
  logic [K-1:0]     out_data_q, out_data_d;
  logic             out_sec_q, out_sec_d;
  logic             out_ded_q, out_ded_d;
  logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0] ded_cnt_q, ded_cnt_d;

  logic [M-1:0]     in_syn_c;
  logic             in_par_c;
  logic             s2_adv_c;
  logic             s1_adv_c;
  logic             out_hs_c;
  logic [CW-1:0]    fixed_c;
  logic [K-1:0]     data_c;
  logic             sec_c;
  logic             ded_c;

  ham_syndrome #(.M(M)) u_syn (
    .code_i (in_code),
    .s_o    (in_syn_c),
    .p_o    (in_par_c)
  );

  assign s2_adv_c = !out_valid_q || out_ready;
  assign s1_adv_c = !s1_valid_q || s2_adv_c;
  assign out_hs_c = out_valid_q && out_ready;

  // Single-bit correction only when overall parity flags an odd error count
  always_comb begin
    fixed_c = s1_code_q;
    for (int unsigned p = 1; p <= N; p++) begin
      if (s1_par_q && (s1_syn_q == M'(p))) fixed_c[IW'(p - 1)] = ~s1_code_q[IW'(p - 1)];
    end
    data_c = '0;
    for (int unsigned j = 0; j < K; j++) begin
      data_c[KW'(j)] = fixed_c[IW'(data_pos(j) - 1)];
    end
    sec_c = s1_par_q;
    ded_c = !s1_par_q && (s1_syn_q != '0);
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_code_d   = s1_code_q;
    s1_syn_d    = s1_syn_q;
    s1_par_d    = s1_par_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sec_d   = out_sec_q;
    out_ded_d   = out_ded_q;
    sec_cnt_d   = sec_cnt_q;
    ded_cnt_d   = ded_cnt_q;

    if (s1_adv_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_code_d = in_code;
        s1_syn_d  = in_syn_c;
        s1_par_d  = in_par_c;
      end
    end

    if (s2_adv_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = data_c;
        out_sec_d  = sec_c;
        out_ded_d  = ded_c;
      end
    end

    // Clear takes priority over a coincident increment
    if (clr_cnt) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else if (out_hs_c) begin
      if (out_sec_q && (sec_cnt_q != '1)) sec_cnt_d = sec_cnt_q + CNT_W'(1);
      if (out_ded_q && (ded_cnt_q != '1)) ded_cnt_d = ded_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_code_q   <= '0;
      s1_syn_q    <= '0;
      s1_par_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sec_q   <= 1'b0;
      out_ded_q   <= 1'b0;
      sec_cnt_q   <= '0;
      ded_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_code_q   <= s1_code_d;
      s1_syn_q    <= s1_syn_d;
      s1_par_q    <= s1_par_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sec_q   <= out_sec_d;
      out_ded_q   <= out_ded_d;
      sec_cnt_q   <= sec_cnt_d;
      ded_cnt_q   <= ded_cnt_d;
    end
  end

  assign in_ready  = s1_adv_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sec   = out_sec_q;
  assign out_ded   = out_ded_q;
  assign sec_cnt   = sec_cnt_q;
  assign ded_cnt   = ded_cnt_q;

endmodule

// File: tb/tb_ham_secded_stream_decoder.sv
// Bench for ham_secded_stream_decoder (M=4, CNT_W=4): vector table, directed corner cases, random stream vs encoder model.
module tb_ham_secded_stream_decoder;

  localparam int unsigned CW = 16;
  localparam int unsigned K = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [CW-1:0] in_code;
  logic          in_ready;
  logic          out_valid;
  logic [K-1:0]  out_data;
  logic          out_sec;
  logic          out_ded;
  logic          out_ready;
  logic          clr_cnt;
  logic [3:0]    sec_cnt;
  logic [3:0]    ded_cnt;

  ham_secded_stream_decoder #(.M(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sec   (out_sec),
    .out_ded   (out_ded),
    .out_ready (out_ready),
    .clr_cnt   (clr_cnt),
    .sec_cnt   (sec_cnt),
    .ded_cnt   (ded_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] code;
    logic [10:0] data;
    logic        sec;
    logic        ded;
  } vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          mdl_sec = 0;
  int          mdl_ded = 0;
  bit          rdy_rand = 1'b0;
  logic [12:0] exp_q[$];
  logic [12:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: data into non-power positions, parity bits chosen for zero syndrome
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    logic        x;
    int          j;
    c = '0;
    j = 0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p - 1] = d[j];
        j++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      x = 1'b0;
      for (int p = 1; p <= 15; p++) if (((p >> b) & 1) != 0) x = x ^ c[p - 1];
      c[(1 << b) - 1] = x;
    end
    c[15] = ^c[14:0];
    return c;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] c);
    logic [10:0] d;
    int          j;
    d = '0;
    j = 0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = c[p - 1];
        j++;
      end
    end
    return d;
  endfunction

  // Scoreboard: compare every output handshake against the expected queue; count flags
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("word", {19'd0, out_data, out_sec, out_ded}, {19'd0, mon_e});
          if (mon_e[1] && mdl_sec < 15) mdl_sec++;
          if (mon_e[0] && mdl_ded < 15) mdl_ded++;
        end
      end
      if (clr_cnt) begin
        mdl_sec = 0;
        mdl_ded = 0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [15:0] c, input logic [12:0] e);
    bit hs;
    hs = 1'b0;
    exp_q.push_back(e);
    in_valid = 1'b1;
    in_code = c;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
    end
    if (!hs) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clr_pulse();
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
  endtask

  function automatic logic [15:0] sec_word(input logic [10:0] d);
    logic [15:0] c;
    c = encode(d);
    c[$urandom_range(0, 15)] ^= 1'b1;
    return c;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[5];
    logic [10:0] d;
    logic [15:0] c;
    int          nerr;
    int          b1;
    int          b2;
    int          t0;

    tbl[0] = '{16'h0000, 11'h000, 1'b0, 1'b0};
    tbl[1] = '{16'h0010, 11'h000, 1'b1, 1'b0};
    tbl[2] = '{16'hFFFF, 11'h7FF, 1'b0, 1'b0};
    tbl[3] = '{16'h7FFF, 11'h7FF, 1'b1, 1'b0};
    tbl[4] = '{16'h0030, 11'h006, 1'b0, 1'b1};

    in_valid = 1'b0;
    in_code = '0;
    out_ready = 1'b0;
    clr_cnt = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("reset_state", {14'd0, out_valid, out_data, out_sec, out_ded, sec_cnt, ded_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Latency: presented before edge t+1, visible after edge t+2
    out_ready = 1'b1;
    exp_q.push_back(13'h0000);
    in_valid = 1'b1;
    in_code = 16'h0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("latency_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("latency_valid", 32'(out_valid), 32'd1);
    drain();

    t0 = cyc;
    for (int i = 0; i < 5; i++) send(tbl[i].code, {tbl[i].data, tbl[i].sec, tbl[i].ded});
    chk("throughput_cycles", 32'(cyc - t0), 32'd5);
    drain();
    chk("table_sec_cnt", 32'(sec_cnt), 32'd2);
    chk("table_ded_cnt", 32'(ded_cnt), 32'd1);

    // Preload, then clear coincident with an sec handshake
    clr_pulse();
    for (int i = 0; i < 14; i++) begin
      d = 11'($urandom);
      send(sec_word(d), {d, 2'b10});
    end
    drain();
    chk("preload_sec_cnt", 32'(sec_cnt), 32'd14);
    clr_cnt = 1'b1;
    d = 11'($urandom);
    send(sec_word(d), {d, 2'b10});
    drain();
    clr_cnt = 1'b0;
    chk("clr_wins_sec_cnt", 32'(sec_cnt), 32'd0);

    for (int i = 0; i < 17; i++) begin
      d = 11'($urandom);
      send(sec_word(d), {d, 2'b10});
    end
    drain();
    chk("sat_sec_cnt", 32'(sec_cnt), 32'd15);
    chk("sat_ded_cnt", 32'(ded_cnt), 32'd0);

    // Random stream with random backpressure and input gaps
    clr_pulse();
    rdy_rand = 1'b1;
    for (int i = 0; i < 100; i++) begin
      d = 11'($urandom);
      c = encode(d);
      nerr = $urandom_range(0, 2);
      b1 = $urandom_range(0, 15);
      b2 = (b1 + 1 + $urandom_range(0, 14)) % 16;
      if (nerr >= 1) c[b1] ^= 1'b1;
      if (nerr == 2) c[b2] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      case (nerr)
        0: send(c, {d, 2'b00});
        1: send(c, {d, 2'b10});
        default: send(c, {extract(c), 2'b01});
      endcase
    end
    drain();
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    chk("rand_sec_cnt", 32'(sec_cnt), 32'(mdl_sec));
    chk("rand_ded_cnt", 32'(ded_cnt), 32'(mdl_ded));

    // Reset with both stages full and output stalled
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    d = 11'($urandom);
    send(encode(d), {d, 2'b00});
    d = 11'($urandom);
    send(encode(d), {d, 2'b00});
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_counters", {24'd0, sec_cnt, ded_cnt}, 32'd0);
    exp_q.delete();
    mdl_sec = 0;
    mdl_ded = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    d = 11'($urandom);
    send(sec_word(d), {d, 2'b10});
    drain();
    chk("postrst_sec_cnt", 32'(sec_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
